regfile_wb_arb: RTL and testbench
=================================

REGFILE_WB_ARB -- requirements
Module: regfile_wb_arb

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset; all state SHALL update on the rising edge of I_clk.
REQ-002 The port list SHALL be as follows, clock and reset first:
- I_clk  in  1  system clock.
- I_rst  in  1  synchronous active-high reset.
- I_validA  in  1  ALU writeback request.
- I_selA  in  3  ALU destination register.
- I_dataA  in  16  ALU result.
- o_readyA  out  1  ALU request accepted this cycle.
- I_validB  in  1  load writeback request.
- I_selB  in  3  load destination register.
- I_dataB  in  16  load data.
- o_readyB  out  1  load request accepted this cycle.
- I_issue  in  1  instruction issued with a destination register.
- I_issue_rd  in  3  destination register of the issued instruction.
- o_en  out  1  register file enable.
- o_we  out  1  register file write enable.
- o_selD  out  3  register file write address.
- o_dataD  out  16  register file write data.
- o_busy  out  8  per-register pending-write scoreboard.
- o_lastB  out  1  source of the most recent grant (1 = B).

Function
REQ-003 The single register file write port SHALL be shared between requesters A and B using round-robin arbitration.
REQ-004 A handshake SHALL complete in a cycle when validX=1 and readyX=1; readyX SHALL be combinational from the valid inputs and the priority pointer.
REQ-005 If only one requester is valid, that requester SHALL be granted (readyX=1) in the same cycle.
REQ-006 If both requesters are valid, the one not granted last SHALL be granted: A when o_lastB=1, B when o_lastB=0.
REQ-007 At most one of o_readyA and o_readyB SHALL be 1 in any cycle; readyX SHALL be 0 whenever validX=0.
REQ-008 A grant in cycle N SHALL produce o_we=1, o_en=1, o_selD=sel, and o_dataD=data of the winner in cycle N+1, registered, for exactly one cycle (latency 1).
REQ-009 In cycles with no grant, o_we and o_en SHALL be 0 in the following cycle; o_selD and o_dataD SHALL hold their previous values.
REQ-010 o_lastB SHALL update on every grant: 1 if B was granted, 0 if A was granted. It SHALL hold when there is no grant.
REQ-011 Back-to-back grants SHALL be supported: one write per cycle, no bubble.
REQ-012 The scoreboard SHALL work per register as follows:
- I_issue=1 sets o_busy[I_issue_rd] on the next edge.
- A grant to register r clears o_busy[r] on the next edge.
REQ-013 If I_issue targets the same register being granted in the same cycle, the set SHALL win and o_busy[r]=1 after the edge.
REQ-014 A grant to a register whose o_busy bit is already 0 SHALL still be performed, and the bit SHALL stay 0.
REQ-015 A requester holding validX=1 without being granted SHALL keep its request; the arbiter SHALL grant it no later than the second cycle in which it is valid (starvation-free).

Reset
REQ-016 While I_rst=1 on a rising edge, the following SHALL apply on the next cycle:
- o_we=0, o_en=0, o_selD=0, o_dataD=0.
- o_busy=8'h00, o_lastB=1 (A has first priority).
REQ-017 While I_rst=1, o_readyA and o_readyB SHALL be 0.
REQ-018 Reset asserted while a write is pending SHALL cancel it: o_we=0 in the cycle after reset, and the request is not completed.

Verification
REQ-019 The bench SHALL cover the following scenarios:
- Reset, then validA only, selA=3, dataA=16'h1234 -> readyA=1 the same cycle; next cycle o_we=1, o_en=1, o_selD=3, o_dataD=16'h1234; o_lastB=0.
- After reset, validA and validB both 1 for 4 cycles -> grant order A, B, A, B; o_we=1 for 4 consecutive cycles.
- Issue rd=5, then validB selB=5 two cycles later -> o_busy=8'h20 until the edge after the grant, then 8'h00.
- Same cycle: I_issue rd=2 and granted write to reg 2 -> o_busy[2]=1 after the edge.
- Assert I_rst in the cycle of a grant to reg 7 with o_busy[7]=1 -> next cycle o_we=0, o_busy=8'h00.
- No valids for 3 cycles -> o_we=0, and o_selD and o_dataD unchanged.

Source files
------------

// File: rtl/regfile_wb_arb.sv
// Round-robin arbiter sharing the register-file write port between ALU (A) and load (B), plus pending-write scoreboard.
// Latency 1 (grant in N -> registered write in N+1); the loser is held off via ready=0 and wins next cycle.
module regfile_wb_arb (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic        I_validA,
  input  logic [2:0]  I_selA,
  input  logic [15:0] I_dataA,
  output logic        o_readyA,
  input  logic        I_validB,
  input  logic [2:0]  I_selB,
  input  logic [15:0] I_dataB,
  output logic        o_readyB,
  input  logic        I_issue,
  input  logic [2:0]  I_issue_rd,
  output logic        o_en,
  output logic        o_we,
  output logic [2:0]  o_selD,
  output logic [15:0] o_dataD,
  output logic [7:0]  o_busy,
  output logic        o_lastB
);

  logic        grant_a, grant_b;
  logic        we_q, we_d;
  logic [2:0]  sel_q, sel_d;
  logic [15:0] data_q, data_d;
  logic [7:0]  busy_q, busy_d;
  logic        lastb_q, lastb_d;

  // Contention goes to whichever side did not win last; reset blocks any handshake.
  always_comb begin
    grant_a = I_validA & ~I_rst & (~I_validB | lastb_q);
    grant_b = I_validB & ~I_rst & (~I_validA | ~lastb_q);
  end

  always_comb begin
    we_d    = grant_a | grant_b;
    sel_d   = sel_q;
    data_d  = data_q;
    lastb_d = lastb_q;
    busy_d  = busy_q;
    if (grant_a) begin
      sel_d           = I_selA;
      data_d          = I_dataA;
      lastb_d         = 1'b0;
      busy_d[I_selA]  = 1'b0;
    end else if (grant_b) begin
      sel_d           = I_selB;
      data_d          = I_dataB;
      lastb_d         = 1'b1;
      busy_d[I_selB]  = 1'b0;
    end
    // A new issue to the register being retired this cycle must stay pending.
    if (I_issue) begin
      busy_d[I_issue_rd] = 1'b1;
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      we_q    <= 1'b0;
      sel_q   <= 3'd0;
      data_q  <= 16'h0000;
      busy_q  <= 8'h00;
      lastb_q <= 1'b1;
    end else begin
      we_q    <= we_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      lastb_q <= lastb_d;
    end
  end

  assign o_readyA = grant_a;
  assign o_readyB = grant_b;
  assign o_we     = we_q;
  assign o_en     = we_q;
  assign o_selD   = sel_q;
  assign o_dataD  = data_q;
  assign o_busy   = busy_q;
  assign o_lastB  = lastb_q;

endmodule

// File: tb/tb_regfile_wb_arb.sv
// Directed bench for regfile_wb_arb: per-scenario tasks with inline expected values.
module tb_regfile_wb_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        va, vb, iss;
  logic [2:0]  sa, sb, rd;
  logic [15:0] da, db;
  logic        rdya, rdyb, en, we, lastb;
  logic [2:0]  seld;
  logic [15:0] datad;
  logic [7:0]  busy;

  int errors = 0;
  int checks = 0;

  regfile_wb_arb dut (
    .I_clk(clk), .I_rst(rst),
    .I_validA(va), .I_selA(sa), .I_dataA(da), .o_readyA(rdya),
    .I_validB(vb), .I_selB(sb), .I_dataB(db), .o_readyB(rdyb),
    .I_issue(iss), .I_issue_rd(rd),
    .o_en(en), .o_we(we), .o_selD(seld), .o_dataD(datad),
    .o_busy(busy), .o_lastB(lastb)
  );

  always #5 clk = ~clk;

  // Apply inputs on the falling edge, then settle so ready can be sampled.
  task automatic drive(input logic r, input logic a_v, input logic [2:0] a_s, input logic [15:0] a_d,
                       input logic b_v, input logic [2:0] b_s, input logic [15:0] b_d,
                       input logic i_v, input logic [2:0] i_rd);
    @(negedge clk);
    rst = r; va = a_v; sa = a_s; da = a_d; vb = b_v; sb = b_s; db = b_d; iss = i_v; rd = i_rd;
    #1;
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    edge_wait();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    edge_wait();
  endtask

  task automatic test_reset();
    drive(1, 1, 3'd1, 16'h1111, 1, 3'd2, 16'h2222, 1, 3'd4);
    checks++;
    if ({rdya, rdyb} !== 2'b00) begin
      errors++; $display("FAIL reset_ready got=%b exp=00", {rdya, rdyb});
    end
    edge_wait();
    checks++;
    if ({we, en, seld, datad, busy, lastb} !== {1'b0, 1'b0, 3'd0, 16'h0000, 8'h00, 1'b1}) begin
      errors++; $display("FAIL reset_state we=%b en=%b sel=%0d data=%h busy=%h lastB=%b exp 0 0 0 0000 00 1",
                         we, en, seld, datad, busy, lastb);
    end
  endtask

  task automatic test_single_a();
    do_reset();
    drive(0, 1, 3'd3, 16'h1234, 0, 0, 0, 0, 0);
    checks++;
    if ({rdya, rdyb} !== 2'b10) begin
      errors++; $display("FAIL single_a_ready got=%b exp=10", {rdya, rdyb});
    end
    edge_wait();
    checks++;
    if ({we, en, seld, datad, lastb} !== {1'b1, 1'b1, 3'd3, 16'h1234, 1'b0}) begin
      errors++; $display("FAIL single_a_write we=%b en=%b sel=%0d data=%h lastB=%b exp 1 1 3 1234 0",
                         we, en, seld, datad, lastb);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    edge_wait();
    checks++;
    if ({we, en} !== 2'b00) begin
      errors++; $display("FAIL single_a_oneshot we/en got=%b exp=00", {we, en});
    end
  endtask

  task automatic test_single_b();
    drive(0, 0, 0, 0, 1, 3'd6, 16'h5A5A, 0, 0);
    checks++;
    if ({rdya, rdyb} !== 2'b01) begin
      errors++; $display("FAIL single_b_ready got=%b exp=01", {rdya, rdyb});
    end
    edge_wait();
    checks++;
    if ({we, seld, datad, lastb} !== {1'b1, 3'd6, 16'h5A5A, 1'b1}) begin
      errors++; $display("FAIL single_b_write we=%b sel=%0d data=%h lastB=%b exp 1 6 5a5a 1",
                         we, seld, datad, lastb);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  exp_rdy [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
    logic [2:0]  exp_sel [4] = '{3'd1, 3'd2, 3'd1, 3'd2};
    logic [15:0] exp_dat [4] = '{16'hA000, 16'hB001, 16'hA002, 16'hB003};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 3'd1, 16'hA000 + 16'(i), 1, 3'd2, 16'hB000 + 16'(i), 0, 0);
      checks++;
      if ({rdya, rdyb} !== exp_rdy[i]) begin
        errors++; $display("FAIL b2b_ready[%0d] got=%b exp=%b", i, {rdya, rdyb}, exp_rdy[i]);
      end
      edge_wait();
      checks++;
      if ({we, en, seld, datad} !== {1'b1, 1'b1, exp_sel[i], exp_dat[i]}) begin
        errors++; $display("FAIL b2b_write[%0d] we=%b en=%b sel=%0d data=%h exp 1 1 %0d %h",
                           i, we, en, seld, datad, exp_sel[i], exp_dat[i]);
      end
    end
  endtask

  task automatic test_scoreboard();
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 3'd5);
    edge_wait();
    checks++;
    if (busy !== 8'h20) begin
      errors++; $display("FAIL sb_set got=%h exp=20", busy);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    edge_wait();
    drive(0, 0, 0, 0, 1, 3'd5, 16'hCAFE, 0, 0);
    checks++;
    if ({busy, rdyb} !== {8'h20, 1'b1}) begin
      errors++; $display("FAIL sb_hold busy=%h readyB=%b exp 20 1", busy, rdyb);
    end
    edge_wait();
    checks++;
    if ({busy, we, seld, datad} !== {8'h00, 1'b1, 3'd5, 16'hCAFE}) begin
      errors++; $display("FAIL sb_clear busy=%h we=%b sel=%0d data=%h exp 00 1 5 cafe", busy, we, seld, datad);
    end
  endtask

  task automatic test_set_wins();
    drive(0, 1, 3'd2, 16'h0202, 0, 0, 0, 1, 3'd2);
    edge_wait();
    checks++;
    if ({busy, we, seld} !== {8'h04, 1'b1, 3'd2}) begin
      errors++; $display("FAIL set_wins busy=%h we=%b sel=%0d exp 04 1 2", busy, we, seld);
    end
    // Write to a register that is not pending: still performed, bit stays clear.
    drive(0, 1, 3'd4, 16'h0404, 0, 0, 0, 0, 0);
    edge_wait();
    checks++;
    if ({busy, we, seld, datad} !== {8'h04, 1'b1, 3'd4, 16'h0404}) begin
      errors++; $display("FAIL clear_idle busy=%h we=%b sel=%0d data=%h exp 04 1 4 0404", busy, we, seld, datad);
    end
  endtask

  task automatic test_reset_cancel();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 3'd7);
    edge_wait();
    checks++;
    if (busy[7] !== 1'b1) begin
      errors++; $display("FAIL cancel_pre busy7=%b exp=1", busy[7]);
    end
    drive(1, 1, 3'd7, 16'h7777, 0, 0, 0, 0, 0);
    checks++;
    if (rdya !== 1'b0) begin
      errors++; $display("FAIL cancel_ready got=%b exp=0", rdya);
    end
    edge_wait();
    checks++;
    if ({we, en, busy, lastb, datad} !== {1'b0, 1'b0, 8'h00, 1'b1, 16'h0000}) begin
      errors++; $display("FAIL cancel_post we=%b en=%b busy=%h lastB=%b data=%h exp 0 0 00 1 0000",
                         we, en, busy, lastb, datad);
    end
  endtask

  task automatic test_idle_hold();
    drive(0, 1, 3'd6, 16'hBEEF, 0, 0, 0, 0, 0);
    edge_wait();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 3'd1, 16'h0000, 0, 3'd2, 16'hFFFF, 0, 0);
      edge_wait();
      checks++;
      if ({we, en, seld, datad, lastb} !== {1'b0, 1'b0, 3'd6, 16'hBEEF, 1'b0}) begin
        errors++; $display("FAIL idle[%0d] we=%b en=%b sel=%0d data=%h lastB=%b exp 0 0 6 beef 0",
                           i, we, en, seld, datad, lastb);
      end
    end
  endtask

  initial begin
    rst = 1; va = 0; vb = 0; iss = 0; sa = 0; sb = 0; rd = 0; da = 0; db = 0;
    test_reset();
    test_single_a();
    test_single_b();
    test_back_to_back();
    test_scoreboard();
    test_set_wins();
    test_reset_cancel();
    test_idle_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
